r5p_gpr_arb: RTL and testbench

- Arbiter/sequencer sharing the r5p general purpose register file (2 read ports, 1 write port) between the core pipeline and a debug abstract-register-access channel.
- Stalls the core, waits for the pipeline to quiesce, performs one debug read or write through the GPR ports, and returns a response.
- Sits between the core decode/writeback stages and the GPR array.

---
 rtl/r5p_gpr_arb_pkg.sv | 26 ++
 rtl/r5p_gpr_mux.sv | 46 ++++
 rtl/r5p_gpr_arb.sv | 157 +++++++++++++++
 tb/tb_r5p_gpr_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/r5p_gpr_arb_pkg.sv
// Shared types for the r5p GPR arbiter: FSM states and debug request/response
// records, sized from the default register file geometry.
package r5p_gpr_arb_pkg;

  localparam int unsigned GPR_AW   = 5;
  localparam int unsigned GPR_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2,
    ST_RSP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                wen;
    logic [GPR_AW-1:0]   adr;
    logic [GPR_XLEN-1:0] wdt;
  } dbg_req_t;

  typedef struct packed {
    logic [GPR_XLEN-1:0] rdt;
    logic                err;
  } dbg_rsp_t;

endpackage

// File: rtl/r5p_gpr_mux.sv
// GPR port mux: the core owns the register file ports except during the single
// debug access cycle (sel), when the latched debug request drives them.
module r5p_gpr_mux #(
  parameter int unsigned AW   = 5,
  parameter int unsigned XLEN = 32
) (
  input  logic            sel,
  input  logic            cor_e_rs1,
  input  logic            cor_e_rs2,
  input  logic            cor_e_rd,
  input  logic [AW-1:0]   cor_a_rs1,
  input  logic [AW-1:0]   cor_a_rs2,
  input  logic [AW-1:0]   cor_a_rd,
  input  logic [XLEN-1:0] cor_d_rd,
  input  logic            dbg_wen,
  input  logic [AW-1:0]   dbg_adr,
  input  logic [XLEN-1:0] dbg_wdt,
  output logic            gpr_e_rs1,
  output logic            gpr_e_rs2,
  output logic            gpr_e_rd,
  output logic [AW-1:0]   gpr_a_rs1,
  output logic [AW-1:0]   gpr_a_rs2,
  output logic [AW-1:0]   gpr_a_rd,
  output logic [XLEN-1:0] gpr_d_rd
);

  always_comb begin
    gpr_e_rs1 = cor_e_rs1;
    gpr_e_rs2 = cor_e_rs2;
    gpr_e_rd  = cor_e_rd;
    gpr_a_rs1 = cor_a_rs1;
    gpr_a_rs2 = cor_a_rs2;
    gpr_a_rd  = cor_a_rd;
    gpr_d_rd  = cor_d_rd;
    if (sel) begin
      // x0 is hardwired, so a debug write to it never reaches the array
      gpr_e_rs1 = !dbg_wen;
      gpr_e_rs2 = 1'b0;
      gpr_e_rd  = dbg_wen && (dbg_adr != '0);
      gpr_a_rs1 = dbg_adr;
      gpr_a_rd  = dbg_adr;
      gpr_d_rd  = dbg_wdt;
    end
  end

endmodule

// File: rtl/r5p_gpr_arb.sv
// Shares the r5p GPR ports between the core and a debug register-access channel:
// stall the core, wait for quiescence (bounded by TMO), do one access, respond.
module r5p_gpr_arb
  import r5p_gpr_arb_pkg::*;
#(
  parameter int unsigned AW   = GPR_AW,
  parameter int unsigned XLEN = GPR_XLEN,
  parameter int unsigned TMO  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cor_e_rs1,
  input  logic            cor_e_rs2,
  input  logic            cor_e_rd,
  input  logic [AW-1:0]   cor_a_rs1,
  input  logic [AW-1:0]   cor_a_rs2,
  input  logic [AW-1:0]   cor_a_rd,
  input  logic [XLEN-1:0] cor_d_rd,
  output logic [XLEN-1:0] cor_d_rs1,
  output logic [XLEN-1:0] cor_d_rs2,
  input  logic            cor_idle,
  output logic            cor_stall,
  output logic            gpr_e_rs1,
  output logic            gpr_e_rs2,
  output logic            gpr_e_rd,
  output logic [AW-1:0]   gpr_a_rs1,
  output logic [AW-1:0]   gpr_a_rs2,
  output logic [AW-1:0]   gpr_a_rd,
  output logic [XLEN-1:0] gpr_d_rd,
  input  logic [XLEN-1:0] gpr_d_rs1,
  input  logic [XLEN-1:0] gpr_d_rs2,
  output logic            gpr_en0,
  input  logic            dbg_vld,
  output logic            dbg_rdy,
  input  logic            dbg_wen,
  input  logic [AW-1:0]   dbg_adr,
  input  logic [XLEN-1:0] dbg_wdt,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rsp_rdt,
  output logic            rsp_err,
  output arb_state_t      arb_state
);

  localparam logic [7:0] TMO_C = 8'(TMO);

  // Handshakes: a transfer happens on the rising clk edge where vld && rdy;
  // vld must hold (with stable payload) until that edge, rdy may toggle freely.

  arb_state_t      state, state_nxt;
  logic [7:0]      cnt, cnt_nxt, cnt_inc;
  logic            req_wen;
  logic [AW-1:0]   req_adr;
  logic [XLEN-1:0] req_wdt;
  logic [XLEN-1:0] rdt_q;
  logic            err_q;
  logic            acc_sel, dbg_hs, rsp_hs, timeout;

  // Outputs are gated by rst so a reset cycle looks idle even before the edge
  assign dbg_rdy   = rst && (state == ST_IDLE);
  assign rsp_vld   = rst && (state == ST_RSP);
  assign cor_stall = rst && ((state == ST_WAIT) || (state == ST_ACC));
  assign acc_sel   = rst && (state == ST_ACC);
  assign dbg_hs    = dbg_vld && dbg_rdy;
  assign rsp_hs    = rsp_vld && rsp_rdy;
  assign cnt_inc   = cnt + 8'd1;
  assign timeout   = (cnt_inc == TMO_C);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (dbg_hs) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (cor_idle) begin
          state_nxt = ST_ACC;
        end else begin
          cnt_nxt = cnt_inc;
          if (timeout) state_nxt = ST_RSP;
        end
      end
      ST_ACC:  state_nxt = ST_RSP;
      ST_RSP:  if (rsp_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_wen <= 1'b0;
      req_adr <= '0;
      req_wdt <= '0;
      rdt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (dbg_hs) begin
        req_wen <= dbg_wen;
        req_adr <= dbg_adr;
        req_wdt <= dbg_wdt;
      end
      if (state == ST_ACC) begin
        if (req_wen) begin
          rdt_q <= '0;
          err_q <= (req_adr == '0);
        end else begin
          // x0 is not stored in the array; its read data is forced to zero
          rdt_q <= (req_adr == '0) ? '0 : gpr_d_rs1;
          err_q <= 1'b0;
        end
      end else if ((state == ST_WAIT) && !cor_idle && timeout) begin
        rdt_q <= '0;
        err_q <= 1'b1;
      end else if (rsp_hs) begin
        rdt_q <= '0;
        err_q <= 1'b0;
      end
    end
  end

  assign rsp_rdt   = rdt_q;
  assign rsp_err   = err_q;
  assign cor_d_rs1 = gpr_d_rs1;
  assign cor_d_rs2 = gpr_d_rs2;
  assign gpr_en0   = 1'b0;
  assign arb_state = state;

  r5p_gpr_mux #(.AW(AW), .XLEN(XLEN)) u_mux (
    .sel       (acc_sel),
    .cor_e_rs1 (cor_e_rs1),
    .cor_e_rs2 (cor_e_rs2),
    .cor_e_rd  (cor_e_rd),
    .cor_a_rs1 (cor_a_rs1),
    .cor_a_rs2 (cor_a_rs2),
    .cor_a_rd  (cor_a_rd),
    .cor_d_rd  (cor_d_rd),
    .dbg_wen   (req_wen),
    .dbg_adr   (req_adr),
    .dbg_wdt   (req_wdt),
    .gpr_e_rs1 (gpr_e_rs1),
    .gpr_e_rs2 (gpr_e_rs2),
    .gpr_e_rd  (gpr_e_rd),
    .gpr_a_rs1 (gpr_a_rs1),
    .gpr_a_rs2 (gpr_a_rs2),
    .gpr_a_rd  (gpr_a_rd),
    .gpr_d_rd  (gpr_d_rd)
  );

endmodule

// File: tb/tb_r5p_gpr_arb.sv
// Bench for r5p_gpr_arb: a behavioural register file behind the GPR ports,
// a table of debug transactions, and hand-written multi-cycle sequences.
module tb_r5p_gpr_arb;
  import r5p_gpr_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        cor_e_rs1, cor_e_rs2, cor_e_rd;
  logic [4:0]  cor_a_rs1, cor_a_rs2, cor_a_rd;
  logic [31:0] cor_d_rd, cor_d_rs1, cor_d_rs2;
  logic        cor_idle, cor_stall;
  logic        gpr_e_rs1, gpr_e_rs2, gpr_e_rd;
  logic [4:0]  gpr_a_rs1, gpr_a_rs2, gpr_a_rd;
  logic [31:0] gpr_d_rd, gpr_d_rs1, gpr_d_rs2;
  logic        gpr_en0;
  logic        dbg_vld, dbg_rdy, dbg_wen;
  logic [4:0]  dbg_adr;
  logic [31:0] dbg_wdt;
  logic        rsp_vld, rsp_rdy, rsp_err;
  logic [31:0] rsp_rdt;
  arb_state_t  arb_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  r5p_gpr_arb #(.AW(5), .XLEN(32), .TMO(4)) dut (
    .clk(clk), .rst(rst),
    .cor_e_rs1(cor_e_rs1), .cor_e_rs2(cor_e_rs2), .cor_e_rd(cor_e_rd),
    .cor_a_rs1(cor_a_rs1), .cor_a_rs2(cor_a_rs2), .cor_a_rd(cor_a_rd),
    .cor_d_rd(cor_d_rd), .cor_d_rs1(cor_d_rs1), .cor_d_rs2(cor_d_rs2),
    .cor_idle(cor_idle), .cor_stall(cor_stall),
    .gpr_e_rs1(gpr_e_rs1), .gpr_e_rs2(gpr_e_rs2), .gpr_e_rd(gpr_e_rd),
    .gpr_a_rs1(gpr_a_rs1), .gpr_a_rs2(gpr_a_rs2), .gpr_a_rd(gpr_a_rd),
    .gpr_d_rd(gpr_d_rd), .gpr_d_rs1(gpr_d_rs1), .gpr_d_rs2(gpr_d_rs2),
    .gpr_en0(gpr_en0),
    .dbg_vld(dbg_vld), .dbg_rdy(dbg_rdy), .dbg_wen(dbg_wen),
    .dbg_adr(dbg_adr), .dbg_wdt(dbg_wdt),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdt(rsp_rdt), .rsp_err(rsp_err),
    .arb_state(arb_state)
  );

  // Register file model; x0 holds junk so the arbiter must zero x0 reads itself
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + 32'(i);
      regs[0] <= 32'h0BAD_F00D;
    end else if (gpr_e_rd) begin
      regs[gpr_a_rd] <= gpr_d_rd;
    end
  end
  assign gpr_d_rs1 = regs[gpr_a_rs1];
  assign gpr_d_rs2 = regs[gpr_a_rs2];

  // scoreboard
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    chk(name, act);
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  adr;
    logic [31:0] wdt;
    int          idle_at;
    int          exp_lat;
    logic [31:0] exp_rdt;
    logic        exp_err;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t vecs[9];

  // driver: one full debug transaction with checks on timing, ports and response
  task automatic run_vec(input int idx, input vec_t v);
    int c, wr_n, rd_n;
    bit stall_ok, wr_ok, got;
    dbg_vld = 1'b1; dbg_wen = v.wen; dbg_adr = v.adr; dbg_wdt = v.wdt;
    cor_idle = (v.idle_at == 0);
    #1;
    expect_eq($sformatf("v%0d_req_rdy", idx), 32'(dbg_rdy), 32'd1);
    @(posedge clk); #1;
    dbg_vld = 1'b0; dbg_wen = 1'b0; dbg_adr = '0; dbg_wdt = '0;
    c = 0; wr_n = 0; rd_n = 0; stall_ok = 1'b1; wr_ok = 1'b1; got = 1'b0;
    while (!got && c < 20) begin
      cor_idle = (c >= v.idle_at);
      #1;
      if (rsp_vld) got = 1'b1;
      else begin
        if (!cor_stall || dbg_rdy) stall_ok = 1'b0;
        if (gpr_e_rd) begin
          wr_n++;
          if (gpr_a_rd !== v.adr || gpr_d_rd !== v.wdt) wr_ok = 1'b0;
        end
        if (gpr_e_rs1) begin
          rd_n++;
          if (gpr_a_rs1 !== v.adr) wr_ok = 1'b0;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    expect_eq($sformatf("v%0d_rsp_seen", idx), 32'(got), 32'd1);
    expect_eq($sformatf("v%0d_latency", idx), 32'(c), 32'(v.exp_lat));
    expect_eq($sformatf("v%0d_rsp_rdt", idx), rsp_rdt, v.exp_rdt);
    expect_eq($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
    expect_eq($sformatf("v%0d_rsp_stall", idx), 32'(cor_stall), 32'd0);
    expect_eq($sformatf("v%0d_stall_hold", idx), 32'(stall_ok), 32'd1);
    expect_eq($sformatf("v%0d_wr_cnt", idx), 32'(wr_n), 32'(v.exp_wr));
    expect_eq($sformatf("v%0d_rd_cnt", idx), 32'(rd_n), 32'(v.exp_rd));
    expect_eq($sformatf("v%0d_port_data", idx), 32'(wr_ok), 32'd1);
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0; cor_idle = 1'b0;
    #1;
    expect_eq($sformatf("v%0d_rsp_drop", idx), 32'(rsp_vld), 32'd0);
    expect_eq($sformatf("v%0d_back_idle", idx), 32'(dbg_rdy), 32'd1);
  endtask

  initial begin
    int c;
    bit got, stall_ok;
    // wen adr wdt idle_at exp_lat exp_rdt exp_err exp_wr exp_rd
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 0,  2, 32'h0,         1'b0, 1, 0};
    vecs[1] = '{1'b0, 5'd5,  32'h0,         0,  2, 32'hDEAD_BEEF, 1'b0, 0, 1};
    vecs[2] = '{1'b1, 5'd0,  32'h1,         0,  2, 32'h0,         1'b1, 0, 0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         0,  2, 32'h0,         1'b0, 0, 1};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 2,  4, 32'h0,         1'b0, 1, 0};
    vecs[5] = '{1'b0, 5'd31, 32'h0,         3,  5, 32'hA5A5_A5A5, 1'b0, 0, 1};
    vecs[6] = '{1'b0, 5'd5,  32'h0,         99, 4, 32'h0,         1'b1, 0, 0};
    vecs[7] = '{1'b1, 5'd9,  32'h1234_5678, 99, 4, 32'h0,         1'b1, 0, 0};
    vecs[8] = '{1'b0, 5'd9,  32'h0,         1,  3, 32'h1000_0009, 1'b0, 0, 1};

    rst = 1'b0; cor_idle = 1'b0; rsp_rdy = 1'b0;
    cor_e_rs1 = 1'b0; cor_e_rs2 = 1'b0; cor_e_rd = 1'b0;
    cor_a_rs1 = '0; cor_a_rs2 = '0; cor_a_rd = '0; cor_d_rd = '0;
    dbg_vld = 1'b1; dbg_wen = 1'b1; dbg_adr = 5'd3; dbg_wdt = 32'h3;

    // reset with a request already pending
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_dbg_rdy", 32'(dbg_rdy), 32'd0);
    expect_eq("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    expect_eq("rst_cor_stall", 32'(cor_stall), 32'd0);
    expect_eq("rst_gpr_en0", 32'(gpr_en0), 32'd0);
    rst = 1'b1;
    #1;
    expect_eq("rel_dbg_rdy", 32'(dbg_rdy), 32'd1);
    expect_eq("rel_state", 32'(arb_state), 32'(ST_IDLE));
    expect_eq("rel_rsp_rdt", rsp_rdt, 32'h0);
    dbg_vld = 1'b0;

    // core owns the ports while idle
    cor_e_rs1 = 1'b1; cor_a_rs1 = 5'd3; cor_e_rs2 = 1'b1; cor_a_rs2 = 5'd4;
    cor_e_rd = 1'b1; cor_a_rd = 5'd6; cor_d_rd = 32'h66;
    #1;
    expect_eq("idle_a_rs1", 32'(gpr_a_rs1), 32'd3);
    expect_eq("idle_e_rs2", 32'(gpr_e_rs2), 32'd1);
    expect_eq("idle_a_rd", 32'(gpr_a_rd), 32'd6);
    expect_eq("idle_d_rd", gpr_d_rd, 32'h66);
    expect_eq("idle_d_rs1", cor_d_rs1, 32'h1000_0003);
    expect_eq("idle_d_rs2", cor_d_rs2, 32'h1000_0004);
    @(posedge clk); #1;
    cor_e_rd = 1'b0; cor_a_rs1 = 5'd6;
    #1;
    expect_eq("idle_wr_thru", cor_d_rs1, 32'h66);
    cor_e_rs1 = 1'b0; cor_e_rs2 = 1'b0; cor_a_rs1 = '0; cor_a_rs2 = '0; cor_a_rd = '0; cor_d_rd = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // core writeback to x7 still in flight when the debug read of x7 arrives
    dbg_vld = 1'b1; dbg_wen = 1'b0; dbg_adr = 5'd7; cor_idle = 1'b0;
    @(posedge clk); #1;
    dbg_vld = 1'b0; dbg_adr = '0;
    cor_e_rd = 1'b1; cor_a_rd = 5'd7; cor_d_rd = 32'h55;
    #1;
    expect_eq("wb_pass_e_rd", 32'(gpr_e_rd), 32'd1);
    expect_eq("wb_pass_d_rd", gpr_d_rd, 32'h55);
    expect_eq("wb_stall", 32'(cor_stall), 32'd1);
    @(posedge clk); #1;
    cor_e_rd = 1'b0; cor_a_rd = '0; cor_d_rd = '0;
    c = 1; got = 1'b0; stall_ok = 1'b1;
    while (!got && c < 20) begin
      cor_idle = (c >= 3);
      #1;
      if (rsp_vld) got = 1'b1;
      else begin
        if (!cor_stall) stall_ok = 1'b0;
        @(posedge clk); #1;
        c++;
      end
    end
    expect_eq("wb_rsp_seen", 32'(got), 32'd1);
    expect_eq("wb_latency", 32'(c), 32'd5);
    expect_eq("wb_stall_hold", 32'(stall_ok), 32'd1);
    expect_eq("wb_rsp_rdt", rsp_rdt, 32'h55);
    expect_eq("wb_rsp_err", 32'(rsp_err), 32'd0);
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0; cor_idle = 1'b0;

    // response back-pressure, then reset while the response is pending
    dbg_vld = 1'b1; dbg_wen = 1'b0; dbg_adr = 5'd5; cor_idle = 1'b1;
    @(posedge clk); #1;
    dbg_adr = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      expect_eq($sformatf("bp%0d_rsp_vld", k), 32'(rsp_vld), 32'd1);
      expect_eq($sformatf("bp%0d_rsp_rdt", k), rsp_rdt, 32'hDEAD_BEEF);
      expect_eq($sformatf("bp%0d_dbg_rdy", k), 32'(dbg_rdy), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    expect_eq("rsp_rst_vld", 32'(rsp_vld), 32'd0);
    @(posedge clk); #1;
    dbg_vld = 1'b0; rst = 1'b1;
    #1;
    expect_eq("rsp_rst_state", 32'(arb_state), 32'(ST_IDLE));
    expect_eq("rsp_rst_vld2", 32'(rsp_vld), 32'd0);
    expect_eq("rsp_rst_rdt", rsp_rdt, 32'h0);
    expect_eq("rsp_rst_err", 32'(rsp_err), 32'd0);
    expect_eq("rsp_rst_rdy", 32'(dbg_rdy), 32'd1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
